// File: rtl/apb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : apb_uart_tx
// Brief    : APB completer that queues bytes in a TX FIFO and sends them as
//            8N1 UART frames (8E1 when APB_UART_TX_PARITY_EN is defined).
// Revision : 1.0
// ============================================================================
module apb_uart_tx #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int FIFO_DEPTH   = 8,
    parameter int TIMEOUT      = 16
) (
    input  logic        pclk,
    input  logic        Reset,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [4:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        tx,
    output logic        tx_busy
);
    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(FIFO_DEPTH + 1);
    localparam int c_BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [4:0] c_ADDR_DATA   = 5'h00;
    localparam logic [4:0] c_ADDR_STATUS = 5'h01;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [c_WW-1:0] r_wait;
    logic            w_full, w_empty, w_push, w_pop, w_stall, w_timeout;
    logic            w_access;
    logic            w_unused;

    state_t          r_state, w_state_n;
    logic [c_BW-1:0] r_baud, w_baud_n;
    logic [2:0]      r_bit, w_bit_n;
    logic [7:0]      r_data, w_data_n;
    logic            r_tx, w_tx_n, w_baud_last;

    assign w_unused  = ^pwdata[31:8];
    assign w_full    = (r_count == c_CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_access  = psel & penable;
    assign w_timeout = (r_wait == c_WW'(TIMEOUT - 1));
    assign tx        = r_tx;
    assign tx_busy   = (r_state != S_IDLE);

    // Full is judged on the registered count, so a same-cycle pop never un-stalls a push.
    always_comb begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        w_push  = 1'b0;
        w_stall = 1'b0;
        if (w_access) begin
            if (paddr == c_ADDR_DATA) begin
                if (!pwrite) begin
                    pready = 1'b1;
                end else if (!w_full) begin
                    pready = 1'b1;
                    w_push = 1'b1;
                end else if (w_timeout) begin
                    pready  = 1'b1;
                    pslverr = 1'b1;
                end else begin
                    w_stall = 1'b1;
                end
            end else if (paddr == c_ADDR_STATUS) begin
                pready = 1'b1;
                if (!pwrite) begin
                    prdata = {25'd0, tx_busy, w_full, w_empty, 4'(r_count)};
                end
            end else begin
                pready  = 1'b1;
                pslverr = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (Reset || !psel || (w_access && pready)) begin
            r_wait <= '0;
        end else if (w_stall) begin
            r_wait <= r_wait + c_WW'(1);
        end
    end

    always_ff @(posedge pclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pwdata[7:0];
        end
    end

    always_ff @(posedge pclk) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

    assign w_baud_last = (r_baud == c_BW'(CLKS_PER_BIT - 1));

    // tx is registered from the next state so the line changes on the same edge as the FSM.
    always_comb begin
        w_state_n = r_state;
        w_baud_n  = r_baud + c_BW'(1);
        w_bit_n   = r_bit;
        w_data_n  = r_data;
        w_pop     = 1'b0;
        w_tx_n    = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_baud_n = '0;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_data_n  = r_mem[r_rd_ptr];
                    w_state_n = S_START;
                end
            end
            S_START: begin
                if (w_baud_last) begin
                    w_baud_n  = '0;
                    w_bit_n   = 3'd0;
                    w_state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_last) begin
                    w_baud_n = '0;
                    w_bit_n  = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
`ifdef APB_UART_TX_PARITY_EN
                        w_state_n = S_PARITY;
`else
                        w_state_n = S_STOP;
`endif
                    end
                end
            end
            S_PARITY: begin
                if (w_baud_last) begin
                    w_baud_n  = '0;
                    w_state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (w_baud_last) begin
                    w_baud_n  = '0;
                    w_state_n = S_IDLE;
                end
            end
            default: begin
                w_baud_n  = '0;
                w_state_n = S_IDLE;
            end
        endcase
        case (w_state_n)
            S_START:  w_tx_n = 1'b0;
            S_DATA:   w_tx_n = w_data_n[w_bit_n];
            S_PARITY: w_tx_n = ^w_data_n;
            default:  w_tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_baud  <= w_baud_n;
            r_bit   <= w_bit_n;
            r_data  <= w_data_n;
            r_tx    <= w_tx_n;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_apb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_uart_tx
// Brief    : Self-checking bench for apb_uart_tx: queue-based line/APB model
//            compared every cycle, plus directed frame and register checks.
// Revision : 1.0
// ============================================================================
module tb_apb_uart_tx;
    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic        pclk = 1'b0;
    logic        Reset = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [4:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr, tx, tx_busy;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    always #5 pclk = ~pclk;

    apb_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .pclk(pclk), .Reset(Reset), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr), .tx(tx), .tx_busy(tx_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bytes waiting in the FIFO, and the exact per-cycle waveform of the frame in flight.
    logic [7:0] m_bytes[$];
    bit         m_line[$];
    logic       m_busy = 1'b0;
    logic       m_tx = 1'b1;
    int         m_stall = 0;

    function automatic void m_apb(output logic rdy, output logic err, output logic [31:0] rd);
        int cnt;
        cnt = m_bytes.size();
        rdy = 1'b0; err = 1'b0; rd = '0;
        if (psel && penable) begin
            if (paddr == 5'h00) begin
                if (!pwrite || cnt < DEPTH) rdy = 1'b1;
                else if (m_stall == TMO - 1) begin rdy = 1'b1; err = 1'b1; end
            end else if (paddr == 5'h01) begin
                rdy = 1'b1;
                if (!pwrite) rd = {25'd0, m_busy, cnt == DEPTH, cnt == 0, 4'(cnt)};
            end else begin
                rdy = 1'b1; err = 1'b1;
            end
        end
    endfunction

    always @(posedge pclk) begin : p_model
        logic rdy, err;
        logic [31:0] rd;
        logic [7:0] b;
        if (Reset) begin
            m_bytes.delete(); m_line.delete();
            m_busy = 1'b0; m_tx = 1'b1; m_stall = 0;
        end else begin
            m_apb(rdy, err, rd);
            if (!m_busy && m_bytes.size() > 0) begin
                b = m_bytes.pop_front();
                repeat (CPB) m_line.push_back(1'b0);
                for (int i = 0; i < 8; i++) repeat (CPB) m_line.push_back(b[i]);
`ifdef APB_UART_TX_PARITY_EN
                repeat (CPB) m_line.push_back(^b);
`endif
                repeat (CPB) m_line.push_back(1'b1);
            end
            if (m_line.size() > 0) begin m_tx = m_line.pop_front(); m_busy = 1'b1; end
            else begin m_tx = 1'b1; m_busy = 1'b0; end
            if (psel && penable && rdy && pwrite && paddr == 5'h00 && !err) m_bytes.push_back(pwdata[7:0]);
            if (!psel || (penable && rdy)) m_stall = 0;
            else if (penable) m_stall++;
        end
    end

    always @(negedge pclk) begin : p_cmp
        logic rdy, err;
        logic [31:0] rd;
        if (cmp_en) begin
            m_apb(rdy, err, rd);
            chk("tx", tx, m_tx);
            chk("tx_busy", tx_busy, m_busy);
            chk("pready", pready, rdy);
            chk("pslverr", pslverr, err);
            chk("prdata", prdata, rd);
        end
    end

    task automatic apb(input logic wr, input logic [4:0] a, input logic [31:0] d,
                       output int stalls, output logic err, output logic [31:0] rd);
        @(posedge pclk); #2;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge pclk); #2;
        penable = 1'b1;
        #3;
        stalls = 0;
        while (pready !== 1'b1 && stalls < 100) begin
            @(posedge pclk); #5;
            stalls++;
        end
        chk("apb_complete", pready, 1'b1);
        err = pslverr;
        rd  = prdata;
        @(posedge pclk); #2;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (tx !== 1'b0 && n < 600) begin @(negedge pclk); n++; end
        chk("frame_start_seen", tx, 1'b0);
    endtask

    // Samples each bit at the middle of its bit time.
    task automatic capture(output logic st, output logic [7:0] d, output logic p, output logic s);
        wait_start();
        repeat (CPB / 2) @(negedge pclk);
        st = tx;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge pclk);
            d[i] = tx;
        end
        repeat (CPB) @(negedge pclk);
        p = tx;
        repeat (CPB) @(negedge pclk);
        s = tx;
    endtask

    task automatic pulse_reset();
        @(posedge pclk); #2; Reset = 1'b1;
        @(posedge pclk); #2; Reset = 1'b0;
    endtask

    initial begin
        logic [7:0]  d;
        logic        st, p, s, err;
        logic [31:0] rd;
        int          stl, lows;

        repeat (3) @(posedge pclk);
        #2; Reset = 1'b0; cmp_en = 1'b1;
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", tx_busy, 1'b0);

        apb(1'b0, 5'h01, 32'h0, stl, err, rd);
        chk("reset_status", rd, 32'h10);
        chk("reset_status_err", err, 1'b0);
        chk("reset_status_wait", stl, 0);

        fork
            capture(st, d, p, s);
            begin
                apb(1'b1, 5'h00, 32'h55, stl, err, rd);
                chk("t1_write_wait", stl, 0);
                chk("t1_write_err", err, 1'b0);
                repeat (30) @(posedge pclk);
                apb(1'b0, 5'h01, 32'h0, stl, err, rd);
                chk("t1_mid_status", rd, 32'h50);
            end
        join
        chk("t1_start", st, 1'b0);
        chk("t1_data", d, 8'h55);
`ifdef APB_UART_TX_PARITY_EN
        chk("t1_parity", p, 1'b0);
        chk("t1_stop", s, 1'b1);
`else
        chk("t1_stop", p, 1'b1);
`endif
        repeat (40) @(posedge pclk);

        fork
            capture(st, d, p, s);
            begin
                for (int k = 1; k <= 9; k++) begin
                    apb(1'b1, 5'h00, 32'(8'hA0 + k), stl, err, rd);
                    chk("t3_write_wait", stl, 0);
                    chk("t3_write_err", err, 1'b0);
                end
                apb(1'b1, 5'h00, 32'hAA, stl, err, rd);
                chk("t3_stall_cycles", stl, 15);
                chk("t3_timeout_err", err, 1'b1);
                apb(1'b0, 5'h01, 32'h0, stl, err, rd);
                chk("t3_full_status", rd, 32'h68);
                apb(1'b1, 5'h05, 32'h99, stl, err, rd);
                chk("t4_bad_addr_wait", stl, 0);
                chk("t4_bad_addr_err", err, 1'b1);
                apb(1'b0, 5'h01, 32'h0, stl, err, rd);
                chk("t4_status_unchanged", rd, 32'h68);
                apb(1'b1, 5'h01, 32'hFF, stl, err, rd);
                chk("status_write_err", err, 1'b0);
                apb(1'b0, 5'h1F, 32'h0, stl, err, rd);
                chk("bad_read_err", err, 1'b1);
            end
        join
        chk("t3_first_byte", d, 8'hA1);

        pulse_reset();
        repeat (5) @(posedge pclk);
        fork
            begin
                wait_start();
                repeat (CPB + 3 * CPB + CPB / 2) @(negedge pclk);
            end
            for (int k = 0; k < 4; k++) apb(1'b1, 5'h00, 32'hF0 + k, stl, err, rd);
        join
        chk("t5_bit3_before_reset", tx, 1'b0);
        @(posedge pclk); #2; Reset = 1'b1;
        @(posedge pclk); #1;
        chk("t5_tx_after_reset", tx, 1'b1);
        chk("t5_busy_after_reset", tx_busy, 1'b0);
        #1; Reset = 1'b0;
        apb(1'b0, 5'h01, 32'h0, stl, err, rd);
        chk("t5_status", rd, 32'h10);
        lows = 0;
        repeat (400) begin @(negedge pclk); if (tx !== 1'b1) lows++; end
        chk("t5_no_frames", lows, 0);

        fork
            capture(st, d, p, s);
            apb(1'b1, 5'h00, 32'h07, stl, err, rd);
        join
        chk("t6_data_07", d, 8'h07);
`ifdef APB_UART_TX_PARITY_EN
        chk("t6_parity_07", p, 1'b1);
        chk("t6_stop_07", s, 1'b1);
`else
        chk("t6_stop_07", p, 1'b1);
`endif
        repeat (40) @(posedge pclk);
        fork
            capture(st, d, p, s);
            apb(1'b1, 5'h00, 32'h03, stl, err, rd);
        join
        chk("t6_data_03", d, 8'h03);
`ifdef APB_UART_TX_PARITY_EN
        chk("t6_parity_03", p, 1'b0);
        chk("t6_stop_03", s, 1'b1);
`else
        chk("t6_stop_03", p, 1'b1);
`endif
        repeat (40) @(posedge pclk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
